// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two request ports.
// Latency: result registered, visible one cycle after the grant.
// Backpressure: a port with an unconsumed response is not granted until it drains.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [WIDTH-1:0]  req0_a_i,
    input  logic [WIDTH-1:0]  req0_b_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [WIDTH-1:0]  rsp0_result_o,
    output logic              rsp0_carry_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [WIDTH-1:0]  req1_a_i,
    input  logic [WIDTH-1:0]  req1_b_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [WIDTH-1:0]  rsp1_result_o,
    output logic              rsp1_carry_o,

    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_carry_i
);

    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp1_result_q;
    logic             rsp0_carry_q, rsp1_carry_q;
    logic             elig0, elig1, grant0, grant1;

    always_comb begin
        // Reset masks eligibility so no grant, capture or ALU drive leaks out of reset.
        elig0  = !reset_i && req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
        elig1  = !reset_i && req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);
        grant0 = elig0 && (!elig1 || last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);

        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end

        rsp0_valid_d = grant0 || (rsp0_valid_q && !rsp0_ready_i);
        rsp1_valid_d = grant1 || (rsp1_valid_q && !rsp1_ready_i);

        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = '0;
        if (grant0) begin
            alu_a_o    = req0_a_i;
            alu_b_o    = req0_b_i;
            alu_ctrl_o = req0_ctrl_i;
        end else if (grant1) begin
            alu_a_o    = req1_a_i;
            alu_b_o    = req1_b_i;
            alu_ctrl_o = req1_ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Result path is deliberately unreset; the valids qualify it.
    always_ff @(posedge clk_i) begin
        if (grant0) begin
            rsp0_result_q <= alu_result_i;
            rsp0_carry_q  <= alu_carry_i;
        end
        if (grant1) begin
            rsp1_result_q <= alu_result_i;
            rsp1_carry_q  <= alu_carry_i;
        end
    end

    assign req0_ready_o  = grant0;
    assign req1_ready_o  = grant1;
    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp1_valid_o  = rsp1_valid_q;
    assign rsp0_result_o = rsp0_result_q;
    assign rsp1_result_o = rsp1_result_q;
    assign rsp0_carry_o  = rsp0_carry_q;
    assign rsp1_carry_o  = rsp1_carry_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters, e.g. the integer execute path (port 0) and the address/branch-compare path (port 1). Each port has a valid/ready request channel carrying operands and a 4-bit ALU control code, plus a valid/ready response channel carrying the registered result and carry. Arbitration is round-robin, at most one grant per cycle. Responses are returned exactly one cycle after acceptance.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width; the code is passed to the ALU unmodified
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request present on port N (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle (grant)
- reqN_a, reqN_b  in  WIDTH  operands
- reqN_ctrl  in  CTRL_W  ALU control code
- rspN_valid  out  1  response held for port N
- rspN_ready  in  1  consumer takes response this cycle
- rspN_result  out  WIDTH  captured ALU result
- rspN_carry  out  1  captured ALU carry-out
- alu_a, alu_b  out  WIDTH  operands to the shared ALU
- alu_ctrl  out  CTRL_W  control code to the shared ALU
- alu_result  in  WIDTH  combinational ALU result
- alu_carry  in  1  combinational ALU carry-out

## Operation
- Slot free for port N: !rspN_valid || rspN_ready. This lets a drain and a new issue happen in the same cycle.
- Eligible N: reqN_valid && slot free N.
- Grant selection:
  - One eligible port: that port wins.
  - Both eligible: the port not equal to last_grant wins.
  - Neither eligible: no grant.
- last_grant updates only on a grant. Its reset value is 1, so port 0 wins the first contention.
- reqN_ready is 1 only for the granted port. It is combinational from the valids, rsp_valid, rsp_ready and last_grant.
- ALU mux:
  - With a grant, alu_a/alu_b/alu_ctrl = the granted port's operands and code.
  - With no grant, all three are driven to 0.
- Capture: on a grant to N, the next edge loads rspN_result/rspN_carry from alu_result/alu_carry and sets rspN_valid = 1.
- Drain: rspN_valid && rspN_ready with no new grant to N clears rspN_valid next edge.
- Hold: while rspN_valid && !rspN_ready, rspN_result/rspN_carry stay stable and port N gets no grant.
- Requester obligations (not checked by this block):
  - Hold operands stable while valid && !ready.
  - Valid must not depend on ready.
- Fairness: under continuous contention with both slots free, grants alternate 0,1,0,1. An eligible port waits at most one cycle.
- The result data path is not reset. Only the valids and last_grant are reset.

## Timing
- Reset values: rsp0_valid = rsp1_valid = 0, last_grant = 1.
  - During reset, req0_ready = req1_ready = 0 and alu_a/alu_b/alu_ctrl = 0, regardless of the inputs.
- Grant-to-response latency: 1 cycle. Accept at edge k makes rsp valid after edge k+1's setup, i.e. visible in cycle k+1.
- Throughput: 1 operation per cycle in aggregate. A single port with rsp_ready tied high can issue every cycle.
- Reset mid-operation: asserting reset in any cycle clears both rsp_valids at that edge and discards any grant in that cycle. After reset, port 0 wins the first contention.
- Simultaneous drain and issue on the same port: the new result replaces the old one and rsp_valid stays 1.
- The ALU path is combinational through this block: arbitration → mux → ALU → capture register, all in one cycle.

## Test plan
The bench models the ALU as alu_result = alu_a + alu_b, with alu_carry = bit WIDTH of the sum.

- Reset: hold reset 2 cycles with both reqN_valid = 1.
  - During reset: reqN_ready = 0, rspN_valid = 0, alu_ctrl = 0.
  - First cycle after reset: req0_ready = 1, req1_ready = 0.
- Single request: req0 a = 8, b = 3, ctrl = 4'b0000, rsp0_ready = 1.
  - req0_ready = 1 in the same cycle.
  - Next cycle: rsp0_valid = 1, rsp0_result = 11, rsp0_carry = 0, alu_ctrl = 0 (idle).
- Contention: both ports valid continuously with rsp_ready = 1; req0 (a = 8, b = 3), req1 (a = 5, b = 7).
  - Grants alternate 0,1,0,1.
  - Results alternate rsp0 = 11 and rsp1 = 12, with exactly one rsp_valid rising per cycle.
- Backpressure: rsp0_ready = 0 after the first port-0 response.
  - req0_ready stays 0 and rsp0_result holds 11.
  - req1 is granted every cycle.
  - Raising rsp0_ready grants req0 in that same cycle (port 1 was last granted); rsp0 updates next cycle.
- Carry: req1 a = 0xFFFFFFFF, b = 1, ctrl = 4'b0000 → rsp1_result = 0, rsp1_carry = 1.
- Reset mid-op: assert reset while rsp1_valid = 1 and rsp1_ready = 0.
  - rsp1_valid = 0 after that edge.
  - Next contention grants port 0 first.
